// File: rtl/data_sram_like_resp.sv
// Memory-side sram_like data responder: one request at a time, fixed accept-to-data_ok latency,
// lane-enabled stores of replicated write data and raw unshifted word loads.
module data_sram_like_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_ok,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  wr_q;
    logic [1:0]            size_q;
    logic [DEPTH_LOG2+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  ok_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic [31:0] mem [2**DEPTH_LOG2];

    // A zero lane mask doubles as the misaligned/illegal indication.
    function automatic logic [3:0] lane_dec(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] lanes;
        lanes = 4'b0000;
        case (size)
            2'd0: lanes = 4'b0001 << a;
            2'd1: lanes = (a == 2'd0) ? 4'b0011 : ((a == 2'd2) ? 4'b1100 : 4'b0000);
            2'd2: lanes = (a == 2'd0) ? 4'b1111 : 4'b0000;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    logic                  idle;
    logic                  sel_wr;
    logic [1:0]            sel_size;
    logic [DEPTH_LOG2+1:0] sel_addr;
    logic [3:0]            sel_lanes;
    logic [3:0]            st_lanes;
    logic                  enter_resp;
    logic                  unused_addr_hi;

    // With LATENCY=1 the response is formed at the accept edge, so use the live inputs then.
    always_comb begin
        idle       = (state_q == IDLE);
        sel_wr     = idle ? data_wr   : wr_q;
        sel_size   = idle ? data_size : size_q;
        sel_addr   = idle ? data_addr[DEPTH_LOG2+1:0] : addr_q;
        sel_lanes  = lane_dec(sel_size, sel_addr[1:0]);
        st_lanes   = lane_dec(size_q, addr_q[1:0]);
        enter_resp = (idle && data_req && (LATENCY == 1)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd1));
    end

    assign unused_addr_hi = ^data_addr[31:DEPTH_LOG2+2];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            if (enter_resp) begin
                ok_q  <= 1'b1;
                err_q <= (sel_lanes == 4'b0000);
                if (sel_lanes == 4'b0000)
                    rdata_q <= '0;
                else if (!sel_wr)
                    rdata_q <= mem[sel_addr[DEPTH_LOG2+1:2]];
            end
            case (state_q)
                IDLE: begin
                    if (data_req) begin
                        wr_q    <= data_wr;
                        size_q  <= data_size;
                        addr_q  <= data_addr[DEPTH_LOG2+1:0];
                        wdata_q <= data_wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY > 1) ? BUSY : RESP;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1)
                        state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store commit at the edge ending RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (resetn && (state_q == RESP) && wr_q) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (st_lanes[k])
                    mem[addr_q[DEPTH_LOG2+1:2]][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign data_addr_ok = (state_q == IDLE);
    assign data_ok      = ok_q;
    assign data_err     = err_q;
    assign data_rdata   = rdata_q;

endmodule
